scan_chain_ctrl: RTL and testbench
==================================

# scan_chain_ctrl

Sequencer for one scan chain of set-capable scan flip-flops (D/SE/SI/SN/CK cells, chain wired Q-to-SI). On request it shifts a test pattern into the chain, pulses one functional capture cycle, and shifts the captured response back out into a parallel register. It can also assert the chain's active-low set for a controlled window with a recovery gap. It sits between the test access logic and the chain's shared SE, SI and SN nets.

## Interface
- CHAIN_LEN, 8: number of cells in the chain (≥2).
- CNT_W, $clog2(CHAIN_LEN+1): shift counter width.
- PRESET_CYC, 2: cycles SN_O is held low during preset (≥1).
- CK  in  1  clock. The controller and the chain share this rising edge.
- RST  in  1  reset. Synchronous and active-high.
- START  in  1  begins a load/capture/unload run. Accepted only in IDLE.
- PRESET  in  1  begins a chain preset. Accepted only in IDLE.
- ABORT  in  1  cancels any run or preset and returns to IDLE.
- PAT_IN  in  CHAIN_LEN  pattern. After loading, bit i sits in cell i. Cell 0 is nearest SI.
- SO  in  1  Q of cell CHAIN_LEN-1.
- SE_O  out  1  scan enable to all cells.
- SI_O  out  1  serial data into cell 0.
- SN_O  out  1  active-low set to all cells.
- BUSY  out  1  high in any non-IDLE state.
- DONE  out  1  one-cycle pulse when RESP is valid.
- RESP  out  CHAIN_LEN  unloaded response. Bit i is the value captured by cell i.

## Operation
- All outputs are registered. Reset values: SE_O=0, SI_O=0, SN_O=1, BUSY=0, DONE=0, RESP=0, state=IDLE, counter=0.
- States and transitions:
  - IDLE:
    - PRESET=1 → PRE. PRESET wins when PRESET and START are both high.
    - Otherwise START=1 → SHIFT. PAT_IN is latched into an internal shift register.
  - SHIFT, CHAIN_LEN cycles, counter k=0..CHAIN_LEN-1:
    - SE_O=1 and SI_O=PAT_IN[CHAIN_LEN-1-k].
    - After the last cycle → CAP.
  - CAP, 1 cycle: SE_O=0 and SI_O=0, so each cell loads its D → UNLD.
  - UNLD, CHAIN_LEN cycles, j=0..CHAIN_LEN-1:
    - SE_O=1 and SI_O=0.
    - On the closing edge of cycle j, SO is stored into RESP[CHAIN_LEN-1-j].
    - After the last cycle → FIN.
  - FIN, 1 cycle: DONE=1, BUSY=0 → IDLE.
  - PRE, PRESET_CYC cycles: SN_O=0 and SE_O=0 → REC.
  - REC, 1 cycle: SN_O=1 and SE_O=0. This covers the SN-to-CK recovery time → IDLE. DONE is not pulsed.
- RESP holds its value until the next run's UNLD overwrites it bit by bit. It is not cleared at START.
- START, PRESET and PAT_IN changes outside IDLE are ignored.
- ABORT has priority over every transition except RST.
  - Any non-IDLE state → IDLE on the next edge.
  - SE_O=0, SN_O=1, no DONE, counter cleared.
  - RESP keeps its partial contents.
- RST at any point, including mid-SHIFT, mid-UNLD or mid-PRE, forces all reset values on the next edge.
- The counter counts 0..CHAIN_LEN-1 and is reloaded to 0 on each state entry. It never wraps past CHAIN_LEN-1.

## Timing
- Output latency:
  - START sampled high at edge t puts BUSY=1 and SE_O=1 visible after t.
  - SI_O for shift bit k is valid in cycle t+k.
  - The first chain shift happens at edge t+1.
- CAP occupies cycle t+CHAIN_LEN. The chain captures at edge t+CHAIN_LEN+1.
- UNLD occupies cycles t+CHAIN_LEN+1 .. t+2·CHAIN_LEN.
- DONE and valid RESP appear in cycle t+2·CHAIN_LEN+1. BUSY drops in that same cycle.
- Run length from START edge to DONE: 2·CHAIN_LEN+1 cycles (17 for CHAIN_LEN=8).
- A new START is accepted in the cycle after DONE at the earliest, because FIN is not IDLE.
- Preset run:
  - SN_O is low for exactly PRESET_CYC cycles.
  - SN_O rises at least one full CK cycle before any subsequent shift edge.
  - BUSY is high for PRESET_CYC+1 cycles.
- SE_O never toggles in the same cycle that SN_O is low.

## Test plan
- Reset: hold RST 2 cycles mid-activity → SE_O=0, SI_O=0, SN_O=1, BUSY=0, DONE=0, RESP=8'h00 on the next edge.
- Full run, CHAIN_LEN=8, behavioural 8-cell chain, PAT_IN=8'hA5, cell D inputs tied 8'h3C:
  - SI_O sequence is 1,0,1,0,0,1,0,1.
  - Chain holds 8'hA5 before CAP.
  - DONE pulses exactly 17 cycles after START.
  - RESP=8'h3C.
- Preset then run, with PRESET and START asserted together:
  - PRESET wins and SN_O=0 for 2 cycles; all cells read 1; REC lasts 1 cycle.
  - START then ignored until IDLE. A subsequent START with D=8'h00 gives RESP=8'h00.
- ABORT in SHIFT cycle 3 → next edge: BUSY=0, SE_O=0, no DONE, RESP unchanged. A START 1 cycle later then completes normally.
- START pulsed during UNLD is ignored: only one DONE, and RESP matches the first run's D.
- RST asserted in UNLD cycle 4 → all outputs at reset values, RESP=8'h00, no DONE for at least 20 cycles without START.

Source files
------------

// File: rtl/scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : scan_chain_ctrl
//  Purpose  : Sequencer for one scan chain of set-capable scan flops.
//             Shifts a pattern in, pulses one capture cycle, and shifts the
//             captured response out into a parallel register. It can also
//             hold the chain's active-low set low for a fixed window, followed
//             by one recovery cycle.
//  Ports    : ck      - shared rising-edge clock (controller and chain)
//             rst     - synchronous active-high reset
//             start   - begin load/capture/unload (accepted in IDLE only)
//             preset  - begin chain preset (accepted in IDLE, wins over start)
//             abort   - cancel any activity, return to IDLE
//             pat_in  - pattern; bit i ends up in cell i (cell 0 nearest SI)
//             so      - Q of the last cell in the chain
//             se_o    - scan enable to all cells
//             si_o    - serial data into cell 0
//             sn_o    - active-low set to all cells
//             busy    - high in any non-IDLE state
//             done    - one-cycle pulse when resp is valid
//             resp    - unloaded response; bit i is what cell i captured
//  Revision : 1.0 - initial release
// ============================================================================
module scan_chain_ctrl #(
    parameter int CHAIN_LEN  = 8,
    parameter int CNT_W      = $clog2(CHAIN_LEN + 1),
    parameter int PRESET_CYC = 2
) (
    input  logic                 ck,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 preset,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] pat_in,
    input  logic                 so,
    output logic                 se_o,
    output logic                 si_o,
    output logic                 sn_o,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] resp
);

    // The same counter times both the shift phases and the preset window,
    // so it must be wide enough for whichever is longer.
    localparam int c_pre_w = $clog2(PRESET_CYC + 1);
    localparam int c_cnt_w = (CNT_W > c_pre_w) ? CNT_W : c_pre_w;

    localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_len_last = c_cnt_w'(CHAIN_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_pre_last = c_cnt_w'(PRESET_CYC - 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_shift = 3'd1;
    localparam logic [2:0] c_st_cap   = 3'd2;
    localparam logic [2:0] c_st_unld  = 3'd3;
    localparam logic [2:0] c_st_fin   = 3'd4;
    localparam logic [2:0] c_st_pre   = 3'd5;
    localparam logic [2:0] c_st_rec   = 3'd6;

    logic [2:0]           r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [CHAIN_LEN-1:0] r_pat;
    logic [CHAIN_LEN-1:0] r_resp;
    logic                 r_se;
    logic                 r_si;
    logic                 r_sn;
    logic                 r_busy;
    logic                 r_done;

    logic [2:0]           w_state_nxt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic                 w_se_nxt;
    logic                 w_si_nxt;
    logic                 w_sn_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;
    logic                 w_accept_start;

    // Outputs are computed for the state being entered and registered, so
    // every pin changes only on the clock edge.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_se_nxt       = 1'b0;
        w_si_nxt       = 1'b0;
        w_sn_nxt       = 1'b1;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        w_accept_start = 1'b0;

        if (abort) begin
            w_state_nxt = c_st_idle;
            w_cnt_nxt   = c_cnt_zero;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (preset) begin
                        w_state_nxt = c_st_pre;
                        w_cnt_nxt   = c_cnt_zero;
                        w_sn_nxt    = 1'b0;
                        w_busy_nxt  = 1'b1;
                    end else if (start) begin
                        w_state_nxt    = c_st_shift;
                        w_cnt_nxt      = c_cnt_zero;
                        w_se_nxt       = 1'b1;
                        w_si_nxt       = pat_in[CHAIN_LEN-1];
                        w_busy_nxt     = 1'b1;
                        w_accept_start = 1'b1;
                    end
                end
                c_st_shift: begin
                    w_busy_nxt = 1'b1;
                    if (r_cnt == c_len_last) begin
                        w_state_nxt = c_st_cap;
                        w_cnt_nxt   = c_cnt_zero;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                        w_se_nxt  = 1'b1;
                        // r_pat is kept pre-shifted so its MSB is the next bit.
                        w_si_nxt  = r_pat[CHAIN_LEN-1];
                    end
                end
                c_st_cap: begin
                    w_state_nxt = c_st_unld;
                    w_cnt_nxt   = c_cnt_zero;
                    w_se_nxt    = 1'b1;
                    w_busy_nxt  = 1'b1;
                end
                c_st_unld: begin
                    if (r_cnt == c_len_last) begin
                        w_state_nxt = c_st_fin;
                        w_cnt_nxt   = c_cnt_zero;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt  = r_cnt + c_cnt_one;
                        w_se_nxt   = 1'b1;
                        w_busy_nxt = 1'b1;
                    end
                end
                c_st_fin: begin
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = c_cnt_zero;
                end
                c_st_pre: begin
                    w_busy_nxt = 1'b1;
                    if (r_cnt == c_pre_last) begin
                        // Recovery cycle: set released, no shift edge yet.
                        w_state_nxt = c_st_rec;
                        w_cnt_nxt   = c_cnt_zero;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                        w_sn_nxt  = 1'b0;
                    end
                end
                c_st_rec: begin
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = c_cnt_zero;
                end
                default: begin
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = c_cnt_zero;
                end
            endcase
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= c_cnt_zero;
            r_se    <= 1'b0;
            r_si    <= 1'b0;
            r_sn    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_se    <= w_se_nxt;
            r_si    <= w_si_nxt;
            r_sn    <= w_sn_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Pattern shift register: the MSB is driven straight onto si_o at
    // acceptance, so the stored copy starts one position ahead.
    always_ff @(posedge ck) begin
        if (rst) begin
            r_pat <= '0;
        end else if (w_accept_start) begin
            r_pat <= pat_in << 1;
        end else if (r_state == c_st_shift) begin
            r_pat <= r_pat << 1;
        end
    end

    // During unload cycle j the chain's last cell holds what cell N-1-j
    // captured; store it on the closing edge of that cycle.
    always_ff @(posedge ck) begin
        if (rst) begin
            r_resp <= '0;
        end else if (r_state == c_st_unld && !abort) begin
            for (int i = 0; i < CHAIN_LEN; i++) begin
                if (r_cnt == c_cnt_w'(CHAIN_LEN - 1 - i)) begin
                    r_resp[i] <= so;
                end
            end
        end
    end

    assign se_o = r_se;
    assign si_o = r_si;
    assign sn_o = r_sn;
    assign busy = r_busy;
    assign done = r_done;
    assign resp = r_resp;

endmodule
`default_nettype wire

// File: tb/tb_scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scan_chain_ctrl
//  Purpose  : Directed bench for scan_chain_ctrl with an 8-cell behavioural
//             set-capable scan chain (cell 0 nearest SI, SO = cell 7).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scan_chain_ctrl;

    localparam int c_n = 8;

    logic           ck     = 1'b0;
    logic           rst    = 1'b1;
    logic           start  = 1'b0;
    logic           preset = 1'b0;
    logic           abort  = 1'b0;
    logic [c_n-1:0] pat_in = '0;
    logic           so;
    logic           se_o;
    logic           si_o;
    logic           sn_o;
    logic           busy;
    logic           done;
    logic [c_n-1:0] resp;

    logic [c_n-1:0] chain = '0;
    logic [c_n-1:0] d_in  = '0;

    int n_checks = 0;
    int n_errors = 0;

    scan_chain_ctrl #(
        .CHAIN_LEN (c_n),
        .PRESET_CYC(2)
    ) u_dut (
        .ck    (ck),
        .rst   (rst),
        .start (start),
        .preset(preset),
        .abort (abort),
        .pat_in(pat_in),
        .so    (so),
        .se_o  (se_o),
        .si_o  (si_o),
        .sn_o  (sn_o),
        .busy  (busy),
        .done  (done),
        .resp  (resp)
    );

    always #5 ck = ~ck;

    // Behavioural chain: asynchronous active-low set, otherwise scan shift
    // or functional capture of d_in on the rising edge.
    always @(posedge ck or negedge sn_o) begin
        if (sn_o === 1'b0)
            chain <= '1;
        else if (se_o)
            chain <= {chain[c_n-2:0], si_o};
        else
            chain <= d_in;
    end
    assign so = chain[c_n-1];

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".se"},   {31'd0, se_o}, 32'd0);
        check({tag, ".si"},   {31'd0, si_o}, 32'd0);
        check({tag, ".sn"},   {31'd0, sn_o}, 32'd1);
        check({tag, ".busy"}, {31'd0, busy}, 32'd0);
        check({tag, ".done"}, {31'd0, done}, 32'd0);
        check({tag, ".resp"}, {24'd0, resp}, 32'h00);
    endtask

    // Pulse start for one edge and count cycles until done (bounded).
    task automatic run_wait(input logic [c_n-1:0] pat, output int cyc);
        pat_in = pat;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        cyc    = 0;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int             cyc;
        int             n_done;
        int             first_done;
        logic [c_n-1:0] seq;

        // Power-on reset, then reset again in the middle of a shift.
        tick();
        tick();
        rst = 1'b0;
        pat_in = 8'hA5;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("rst_mid_shift");
        rst = 1'b0;
        tick();

        // Full run: pattern A5, capture data 3C.
        d_in   = 8'h3C;
        pat_in = 8'hA5;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("run1.busy0", {31'd0, busy}, 32'd1);
        check("run1.se0",   {31'd0, se_o}, 32'd1);
        seq = '0;
        for (int k = 0; k < c_n; k++) begin
            seq[c_n-1-k] = si_o;
            tick();
        end
        check("run1.si_seq",   {24'd0, seq},   32'hA5);
        check("run1.cap_se",   {31'd0, se_o},  32'd0);
        check("run1.chain_pre_cap", {24'd0, chain}, 32'hA5);
        cyc = c_n;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
        check("run1.latency", cyc, 32'd17);
        check("run1.resp",    {24'd0, resp}, 32'h3C);
        check("run1.busy_fin", {31'd0, busy}, 32'd0);
        tick();
        check("run1.done_1cyc", {31'd0, done}, 32'd0);

        // Preset and start together: preset wins; start held is ignored.
        preset = 1'b1;
        start  = 1'b1;
        tick();
        preset = 1'b0;
        check("pre.sn0",    {31'd0, sn_o}, 32'd0);
        check("pre.busy0",  {31'd0, busy}, 32'd1);
        check("pre.se0",    {31'd0, se_o}, 32'd0);
        check("pre.chain",  {24'd0, chain}, 32'hFF);
        tick();
        check("pre.sn1",    {31'd0, sn_o}, 32'd0);
        tick();
        check("pre.rec_sn", {31'd0, sn_o}, 32'd1);
        check("pre.rec_busy", {31'd0, busy}, 32'd1);
        tick();
        check("pre.idle_busy", {31'd0, busy}, 32'd0);
        check("pre.no_done",   {31'd0, done}, 32'd0);
        start = 1'b0;
        d_in  = 8'h00;
        run_wait(8'h3C, cyc);
        check("run2.latency", cyc, 32'd17);
        check("run2.resp",    {24'd0, resp}, 32'h00);
        tick();

        // Abort in shift cycle 3, then a normal run one cycle later.
        d_in   = 8'hC3;
        pat_in = 8'h0F;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort.busy", {31'd0, busy}, 32'd0);
        check("abort.se",   {31'd0, se_o}, 32'd0);
        check("abort.sn",   {31'd0, sn_o}, 32'd1);
        check("abort.done", {31'd0, done}, 32'd0);
        check("abort.resp", {24'd0, resp}, 32'h00);
        tick();
        run_wait(8'h55, cyc);
        check("run3.latency", cyc, 32'd17);
        check("run3.resp",    {24'd0, resp}, 32'hC3);
        tick();

        // Start pulsed during unload must be ignored.
        d_in   = 8'h96;
        pat_in = 8'h12;
        start  = 1'b1;
        tick();
        start      = 1'b0;
        n_done     = 0;
        first_done = 0;
        for (int c = 1; c <= 40; c++) begin
            start = (c == 12);
            tick();
            if (done) begin
                n_done++;
                if (first_done == 0) first_done = c;
            end
        end
        start = 1'b0;
        check("unld_start.n_done", n_done, 32'd1);
        check("unld_start.latency", first_done, 32'd17);
        check("unld_start.resp", {24'd0, resp}, 32'h96);

        // Reset during unload cycle 4.
        d_in   = 8'hFF;
        pat_in = 8'hAA;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 13; c++) tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("rst_unld");
        rst    = 1'b0;
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done || busy) n_done++;
        end
        check("rst_unld.quiet", n_done, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
